acc_mem_arbiter: RTL and testbench

//  Shares the single Data Memory accelerator port between NUM_ACC accelerator control units.

---
 rtl/acc_arb_pkg.sv | 16 +
 rtl/acc_rr_picker.sv | 46 ++++
 rtl/acc_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_acc_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_arb_pkg.sv
// Shared types and constants for the accelerator memory arbiter.
//   arb_state_t : arbiter FSM states
//   ARB_OP_RD / ARB_OP_WR : registered operation encoding, also drives mem_wr
package acc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    localparam logic ARB_OP_RD = 1'b0;
    localparam logic ARB_OP_WR = 1'b1;

endpackage

// File: rtl/acc_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping from NUM_ACC-1 back to 0.
// Ports:
//   req : per-requester request vector
//   ptr : index that has highest priority this cycle
//   any : at least one request is asserted
//   idx : index of the chosen requester (valid when any=1)
module acc_rr_picker #(
    parameter int NUM_ACC = 4,
    parameter int IDX_W   = $clog2(NUM_ACC)
) (
    input  logic [NUM_ACC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_ACC);

    logic [2*NUM_ACC-1:0] dbl;
    logic [NUM_ACC-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    // Doubling the vector lets a plain right shift perform the rotation, so bit k
    // of rot is requester (ptr + k) mod NUM_ACC.
    assign dbl = {req, req};

    always_comb begin
        any = |req;
        rot = NUM_ACC'(dbl >> ptr);
        off = '0;
        // Descending scan: the lowest set offset is assigned last and wins.
        for (int k = NUM_ACC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NUM_W) begin
            sum = sum - NUM_W;
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Shares the single data-memory accelerator port between NUM_ACC accelerator
// control units with round-robin fairness. One transaction is in flight at a
// time; no new access is started while the CPU owns the memory.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   acc_rd_en/addr        : per-requester read request, held until rd_data_valid
//   acc_wr_en/addr/data   : per-requester write request, held until wr_done
//   acc_rd_data           : shared read-return bus, holds last captured read
//   acc_rd_data_valid     : one-hot, one-cycle read-complete pulse
//   acc_wr_done           : one-hot, one-cycle write-complete pulse
//   cpu_mem_busy          : CPU owns the memory; blocks a new grant
//   mem_en/wr/addr/wr_data: memory access strobe and command
//   mem_rd_data           : memory read data, MEM_RD_LATENCY cycles after issue
module acc_mem_arbiter
    import acc_arb_pkg::*;
#(
    parameter int NUM_ACC        = 4,
    parameter int ADDR_SIZE      = 16,
    parameter int RD_DATA_SIZE   = 512,
    parameter int WR_DATA_SIZE   = 32,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_ACC-1:0]                acc_rd_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]      acc_rd_addr,
    input  logic [NUM_ACC-1:0]                acc_wr_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]      acc_wr_addr,
    input  logic [NUM_ACC*WR_DATA_SIZE-1:0]   acc_wr_data,
    output logic [RD_DATA_SIZE-1:0]           acc_rd_data,
    output logic [NUM_ACC-1:0]                acc_rd_data_valid,
    output logic [NUM_ACC-1:0]                acc_wr_done,
    input  logic                              cpu_mem_busy,
    output logic                              mem_en,
    output logic                              mem_wr,
    output logic [ADDR_SIZE-1:0]              mem_addr,
    output logic [WR_DATA_SIZE-1:0]           mem_wr_data,
    input  logic [RD_DATA_SIZE-1:0]           mem_rd_data
);

    localparam int IDX_W = $clog2(NUM_ACC);
    localparam int CNT_W = $clog2(MEM_RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT  = CNT_W'(MEM_RD_LATENCY);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ACC - 1);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [IDX_W-1:0]        grant;
    logic [IDX_W-1:0]        rr_ptr;
    logic                    op;
    logic [CNT_W-1:0]        cnt;
    logic [RD_DATA_SIZE-1:0] rd_data_q;

    logic [NUM_ACC-1:0]      req;
    logic                    pick_any;
    logic [IDX_W-1:0]        pick_idx;
    logic                    start;

    logic [ADDR_SIZE-1:0]    rd_addr_a [NUM_ACC];
    logic [ADDR_SIZE-1:0]    wr_addr_a [NUM_ACC];
    logic [WR_DATA_SIZE-1:0] wr_data_a [NUM_ACC];

    for (genvar i = 0; i < NUM_ACC; i++) begin : g_unpack
        assign rd_addr_a[i] = acc_rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
        assign wr_addr_a[i] = acc_wr_addr[i*ADDR_SIZE +: ADDR_SIZE];
        assign wr_data_a[i] = acc_wr_data[i*WR_DATA_SIZE +: WR_DATA_SIZE];
    end

    assign req   = acc_rd_en | acc_wr_en;
    assign start = (state == IDLE) && pick_any && !cpu_mem_busy;

    acc_rr_picker #(
        .NUM_ACC (NUM_ACC),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req (req),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            op        <= ARB_OP_RD;
            rr_ptr    <= '0;
            cnt       <= '0;
            rd_data_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        grant <= pick_idx;
                        // A requester asserting both enables is served as a read first.
                        op    <= acc_rd_en[pick_idx] ? ARB_OP_RD : ARB_OP_WR;
                    end
                end
                ISSUE: begin
                    cnt <= CNT_W'(1);
                end
                RD_WAIT: begin
                    if (cnt == LAT) begin
                        rd_data_q <= mem_rd_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Move past the requester just served so it loses any tie next time.
                    rr_ptr <= (grant == LAST) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = (op == ARB_OP_WR) ? RESP : RD_WAIT;
            RD_WAIT: if (cnt == LAT) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en            = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = '0;
        mem_wr_data       = '0;
        acc_rd_data_valid = '0;
        acc_wr_done       = '0;
        case (state)
            ISSUE: begin
                mem_en = 1'b1;
                mem_wr = op;
                if (op == ARB_OP_WR) begin
                    mem_addr    = wr_addr_a[grant];
                    mem_wr_data = wr_data_a[grant];
                end else begin
                    mem_addr    = rd_addr_a[grant];
                end
            end
            RESP: begin
                if (op == ARB_OP_WR) begin
                    acc_wr_done[grant] = 1'b1;
                end else begin
                    acc_rd_data_valid[grant] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign acc_rd_data = rd_data_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
module tb_acc_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int RDW = 512;
    localparam int WDW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: MEM_RD_LATENCY = 1
    logic [N-1:0]     rd_en, wr_en, rd_vld, wr_done;
    logic [N*AW-1:0]  rd_addr, wr_addr;
    logic [N*WDW-1:0] wr_data;
    logic             busy, mem_en, mem_wr;
    logic [RDW-1:0]   rd_data, mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic [WDW-1:0]   mem_wdata;

    // Instance B: MEM_RD_LATENCY = 4
    logic [N-1:0]     b_rd_en, b_wr_en, b_rd_vld, b_wr_done;
    logic [N*AW-1:0]  b_rd_addr, b_wr_addr;
    logic [N*WDW-1:0] b_wr_data;
    logic             b_busy, b_mem_en, b_mem_wr;
    logic [RDW-1:0]   b_rd_data, b_mem_rdata;
    logic [AW-1:0]    b_mem_addr;
    logic [WDW-1:0]   b_mem_wdata;

    acc_mem_arbiter #(.NUM_ACC(N), .ADDR_SIZE(AW), .RD_DATA_SIZE(RDW),
                      .WR_DATA_SIZE(WDW), .MEM_RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .acc_rd_en(rd_en), .acc_rd_addr(rd_addr),
        .acc_wr_en(wr_en), .acc_wr_addr(wr_addr), .acc_wr_data(wr_data),
        .acc_rd_data(rd_data), .acc_rd_data_valid(rd_vld), .acc_wr_done(wr_done),
        .cpu_mem_busy(busy),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wdata), .mem_rd_data(mem_rdata)
    );

    acc_mem_arbiter #(.NUM_ACC(N), .ADDR_SIZE(AW), .RD_DATA_SIZE(RDW),
                      .WR_DATA_SIZE(WDW), .MEM_RD_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .acc_rd_en(b_rd_en), .acc_rd_addr(b_rd_addr),
        .acc_wr_en(b_wr_en), .acc_wr_addr(b_wr_addr), .acc_wr_data(b_wr_data),
        .acc_rd_data(b_rd_data), .acc_rd_data_valid(b_rd_vld), .acc_wr_done(b_wr_done),
        .cpu_mem_busy(b_busy),
        .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_wr_data(b_mem_wdata), .mem_rd_data(b_mem_rdata)
    );

    function automatic logic [RDW-1:0] pattern(input logic [AW-1:0] a);
        return {32{a ^ 16'hA5A5}};
    endfunction

    function automatic logic [RDW-1:0] junk();
        return {16{$urandom}};
    endfunction

    // Memory models: read data is valid exactly MEM_RD_LATENCY cycles after issue,
    // random junk at every other time.
    logic [RDW-1:0] a_q;
    always @(posedge clk) a_q <= (mem_en && !mem_wr) ? pattern(mem_addr) : junk();
    assign mem_rdata = a_q;

    logic [RDW-1:0] b_pipe [4];
    always @(posedge clk) begin
        b_pipe[0] <= (b_mem_en && !b_mem_wr) ? pattern(b_mem_addr) : junk();
        for (int k = 1; k < 4; k++) b_pipe[k] <= b_pipe[k-1];
    end
    assign b_mem_rdata = b_pipe[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0; busy = 1'b0;
        b_rd_en = '0; b_wr_en = '0; b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        tests++; if (mem_addr !== '0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        tests++; if (mem_wdata !== '0) begin fails++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        tests++; if (rd_vld !== '0) begin fails++; $display("FAIL reset_rd_vld: got %b want 0", rd_vld); end
        tests++; if (wr_done !== '0) begin fails++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
        tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got nonzero want 0"); end
        tests++; if (b_mem_en !== 1'b0) begin fails++; $display("FAIL reset_b_mem_en: got %b want 0", b_mem_en); end
        tests++; if (b_rd_vld !== '0) begin fails++; $display("FAIL reset_b_rd_vld: got %b want 0", b_rd_vld); end
        tests++; if (b_rd_data !== '0) begin fails++; $display("FAIL reset_b_rd_data: got nonzero want 0"); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        step();
        wr_addr[1*AW +: AW] = 16'h5000; wr_data[1*WDW +: WDW] = 32'h5; wr_en[1] = 1'b1;
        @(negedge clk);
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL wr_early_en: got %b want 0", mem_en); end
        step(); @(negedge clk);
        tests++; if ({mem_en, mem_wr} !== 2'b11) begin fails++; $display("FAIL wr_issue: got en/wr %b want 11", {mem_en, mem_wr}); end
        tests++; if (mem_addr !== 16'h5000) begin fails++; $display("FAIL wr_addr: got %h want 5000", mem_addr); end
        tests++; if (mem_wdata !== 32'h5) begin fails++; $display("FAIL wr_data: got %h want 5", mem_wdata); end
        tests++; if (wr_done !== 4'b0000) begin fails++; $display("FAIL wr_done_early: got %b want 0000", wr_done); end
        step(); @(negedge clk);
        tests++; if (wr_done !== 4'b0010) begin fails++; $display("FAIL wr_done: got %b want 0010", wr_done); end
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL wr_en_after: got %b want 0", mem_en); end
        step(); wr_en[1] = 1'b0; @(negedge clk);
        tests++; if (wr_done !== 4'b0000) begin fails++; $display("FAIL wr_done_once: got %b want 0000", wr_done); end
    endtask

    task automatic test_single_read();
        step();
        rd_addr[2*AW +: AW] = 16'h1000; rd_en[2] = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step();
            @(negedge clk);
            tests++;
            if (rd_vld !== ((k == 3) ? 4'b0100 : 4'b0000)) begin
                fails++; $display("FAIL rd_vld_c%0d: got %b want %b", k, rd_vld, (k == 3) ? 4'b0100 : 4'b0000);
            end
            if (k == 1) begin
                tests++;
                if ({mem_en, mem_wr, mem_addr} !== {2'b10, 16'h1000}) begin
                    fails++; $display("FAIL rd_issue: got en=%b wr=%b addr=%h want 1 0 1000", mem_en, mem_wr, mem_addr);
                end
            end
        end
        tests++; if (rd_data !== pattern(16'h1000)) begin fails++; $display("FAIL rd_data: got %h want %h", rd_data[31:0], pattern(16'h1000)[31:0]); end
        step(); rd_en[2] = 1'b0;
        repeat (3) step();
        @(negedge clk);
        tests++; if (rd_data !== pattern(16'h1000)) begin fails++; $display("FAIL rd_data_hold: got %h want %h", rd_data[31:0], pattern(16'h1000)[31:0]); end
    endtask

    task automatic test_fairness();
        int order[$];
        int cyc;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = AW'($urandom);
        rd_en = 4'hF;
        cyc = 0;
        while (order.size() < 5 && cyc < 60) begin
            step(); @(negedge clk); cyc++;
            if (rd_vld !== '0) begin
                tests++; if (!$onehot(rd_vld)) begin fails++; $display("FAIL fair_onehot: got %b want one-hot", rd_vld); end
                for (int i = 0; i < N; i++) begin
                    if (rd_vld[i]) begin
                        order.push_back(i);
                        tests++;
                        if (rd_data !== pattern(rd_addr[i*AW +: AW])) begin
                            fails++; $display("FAIL fair_data_%0d: got %h want %h", i, rd_data[31:0], pattern(rd_addr[i*AW +: AW])[31:0]);
                        end
                    end
                end
            end
        end
        step(); rd_en = '0;
        tests++;
        if (order.size() < 5) begin
            fails++; $display("FAIL fair_timeout: got %0d pulses want 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests++;
                if (order[k] != k % N) begin fails++; $display("FAIL fair_order_%0d: got %0d want %0d", k, order[k], k % N); end
            end
        end
        repeat (3) step();
    endtask

    task automatic test_cpu_block();
        logic [AW-1:0]  a;
        logic [WDW-1:0] d;
        a = AW'($urandom); d = $urandom;
        step();
        busy = 1'b1; wr_addr[0 +: AW] = a; wr_data[0 +: WDW] = d; wr_en[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            @(negedge clk);
            tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL busy_block_%0d: got %b want 0", k, mem_en); end
        end
        step(); busy = 1'b0; @(negedge clk);
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL busy_drop_cycle: got %b want 0", mem_en); end
        step(); @(negedge clk);
        tests++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {2'b11, a, d}) begin
            fails++; $display("FAIL busy_issue: got en=%b wr=%b addr=%h data=%h want 1 1 %h %h", mem_en, mem_wr, mem_addr, mem_wdata, a, d);
        end
        step(); @(negedge clk);
        tests++; if (wr_done !== 4'b0001) begin fails++; $display("FAIL busy_done: got %b want 0001", wr_done); end
        step(); wr_en[0] = 1'b0;
    endtask

    task automatic test_both_en();
        logic [AW-1:0]  ra, wa;
        logic [WDW-1:0] d;
        ra = AW'($urandom); wa = AW'($urandom); d = $urandom;
        step();
        rd_addr[3*AW +: AW] = ra; wr_addr[3*AW +: AW] = wa; wr_data[3*WDW +: WDW] = d;
        rd_en[3] = 1'b1; wr_en[3] = 1'b1;
        step(); @(negedge clk);
        tests++;
        if ({mem_en, mem_wr, mem_addr} !== {2'b10, ra}) begin
            fails++; $display("FAIL both_rd_first: got en=%b wr=%b addr=%h want 1 0 %h", mem_en, mem_wr, mem_addr, ra);
        end
        step(); step(); @(negedge clk);
        tests++;
        if ({rd_vld, wr_done} !== {4'b1000, 4'b0000}) begin
            fails++; $display("FAIL both_rd_vld: got vld=%b done=%b want 1000 0000", rd_vld, wr_done);
        end
        step(); rd_en[3] = 1'b0; @(negedge clk);
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL both_idle: got %b want 0", mem_en); end
        step(); @(negedge clk);
        tests++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {2'b11, wa, d}) begin
            fails++; $display("FAIL both_wr_second: got en=%b wr=%b addr=%h data=%h want 1 1 %h %h", mem_en, mem_wr, mem_addr, mem_wdata, wa, d);
        end
        step(); @(negedge clk);
        tests++; if (wr_done !== 4'b1000) begin fails++; $display("FAIL both_wr_done: got %b want 1000", wr_done); end
        step(); wr_en[3] = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic [AW-1:0] x, y, z;
        x = 16'h0123; y = 16'h0456; z = 16'h0789;
        // Read by requester 1 moves the pointer to 2 and loads acc_rd_data.
        step();
        b_rd_addr[1*AW +: AW] = x; b_rd_en[1] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step();
            @(negedge clk);
            tests++;
            if (b_rd_vld !== ((k == 6) ? 4'b0010 : 4'b0000)) begin
                fails++; $display("FAIL l4_vld_c%0d: got %b want %b", k, b_rd_vld, (k == 6) ? 4'b0010 : 4'b0000);
            end
        end
        tests++; if (b_rd_data !== pattern(x)) begin fails++; $display("FAIL l4_data: got %h want %h", b_rd_data[31:0], pattern(x)[31:0]); end
        step(); b_rd_en[1] = 1'b0;
        // Read by requester 3, reset while it waits on memory.
        step();
        b_rd_addr[3*AW +: AW] = y; b_rd_en[3] = 1'b1;
        step(); @(negedge clk);
        tests++; if (b_mem_addr !== y || b_mem_en !== 1'b1) begin fails++; $display("FAIL rst_pre_issue: got en=%b addr=%h want 1 %h", b_mem_en, b_mem_addr, y); end
        step();
        step(); rst = 1'b1; @(negedge clk);
        tests++;
        if ({b_mem_en, b_mem_wr, b_mem_addr, b_mem_wdata, b_rd_vld, b_wr_done} !== '0) begin
            fails++; $display("FAIL rst_outputs: got en=%b addr=%h vld=%b want all 0", b_mem_en, b_mem_addr, b_rd_vld);
        end
        tests++; if (b_rd_data !== '0) begin fails++; $display("FAIL rst_rd_data: got %h want 0", b_rd_data[31:0]); end
        step(); @(negedge clk);
        tests++; if (b_rd_vld !== '0) begin fails++; $display("FAIL rst_no_pulse: got %b want 0", b_rd_vld); end
        step(); rst = 1'b0;
        b_rd_addr[1*AW +: AW] = z; b_rd_en[1] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step();
            @(negedge clk);
            tests++;
            if (b_rd_vld !== ((k == 6) ? 4'b0010 : 4'b0000)) begin
                fails++; $display("FAIL post_rst_vld_c%0d: got %b want %b", k, b_rd_vld, (k == 6) ? 4'b0010 : 4'b0000);
            end
            if (k == 1) begin
                tests++; if (b_mem_addr !== z) begin fails++; $display("FAIL post_rst_grant: got addr %h want %h", b_mem_addr, z); end
            end
        end
        tests++; if (b_rd_data !== pattern(z)) begin fails++; $display("FAIL post_rst_data: got %h want %h", b_rd_data[31:0], pattern(z)[31:0]); end
        step(); b_rd_en = '0;
        repeat (10) step();
    endtask

    // Transaction-level model: a grant decided in an idle cycle c issues at c+1,
    // completes at c+2 (write) or c+3 (read, latency 1), and the arbiter is free
    // again the cycle after completion.
    task automatic test_random();
        int free_at, issue_cyc, pulse_cyc, g, ptr, idx;
        bit g_wr, found;
        logic [AW-1:0]  g_addr;
        logic [WDW-1:0] g_data;
        logic [RDW-1:0] exp_rd;
        logic [N-1:0]   exp_vld, exp_done;
        bit pend [N];
        rst = 1'b1;
        rd_en = '0; wr_en = '0; busy = 1'b0;
        step(); rst = 1'b0;
        free_at = 0; issue_cyc = -1; pulse_cyc = -1; g = 0; ptr = 0;
        g_wr = 1'b0; g_addr = '0; g_data = '0; exp_rd = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    rd_en[i] = 1'b0; wr_en[i] = 1'b0;
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        rd_addr[i*AW +: AW]   = AW'($urandom);
                        wr_addr[i*AW +: AW]   = AW'($urandom);
                        wr_data[i*WDW +: WDW] = $urandom;
                        case ($urandom_range(0, 3))
                            0, 1:    rd_en[i] = 1'b1;
                            2:       wr_en[i] = 1'b1;
                            default: begin rd_en[i] = 1'b1; wr_en[i] = 1'b1; end
                        endcase
                    end
                end
            end
            busy = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            tests++;
            if (mem_en !== (cyc == issue_cyc)) begin
                fails++; $display("FAIL rnd_mem_en c%0d: got %b want %b", cyc, mem_en, cyc == issue_cyc);
            end
            if (cyc == issue_cyc) begin
                tests++;
                if (mem_wr !== g_wr || mem_addr !== g_addr || (g_wr && mem_wdata !== g_data)) begin
                    fails++; $display("FAIL rnd_issue c%0d: got wr=%b addr=%h data=%h want %b %h %h", cyc, mem_wr, mem_addr, mem_wdata, g_wr, g_addr, g_data);
                end
            end
            exp_vld = '0; exp_done = '0;
            if (cyc == pulse_cyc) begin
                if (g_wr) exp_done[g] = 1'b1;
                else begin exp_vld[g] = 1'b1; exp_rd = pattern(g_addr); end
                pend[g] = 1'b0;
                ptr = (g + 1) % N;
            end
            tests++;
            if (rd_vld !== exp_vld || wr_done !== exp_done) begin
                fails++; $display("FAIL rnd_pulse c%0d: got vld=%b done=%b want %b %b", cyc, rd_vld, wr_done, exp_vld, exp_done);
            end
            tests++;
            if (rd_data !== exp_rd) begin
                fails++; $display("FAIL rnd_rd_data c%0d: got %h want %h", cyc, rd_data[31:0], exp_rd[31:0]);
            end
            if (cyc >= free_at && (rd_en | wr_en) != '0 && !busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (!found && (rd_en[idx] || wr_en[idx])) begin
                        found = 1'b1; g = idx;
                    end
                end
                g_wr   = !rd_en[g];
                g_addr = g_wr ? wr_addr[g*AW +: AW] : rd_addr[g*AW +: AW];
                g_data = wr_data[g*WDW +: WDW];
                issue_cyc = cyc + 1;
                pulse_cyc = cyc + 2 + (g_wr ? 0 : 1);
                free_at   = pulse_cyc + 1;
            end
        end
        step(); rd_en = '0; wr_en = '0; busy = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_fairness();
        test_cpu_block();
        test_both_en();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
